// File: rtl/led_pio_sequencer.sv
// LED pattern sequencer: drives single-cycle PIO slave writes from a prescaled
// pattern engine and a software request path, arbitrated round-robin.
module led_pio_sequencer #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter logic [7:0]  INIT_PATTERN = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic        sw_req,
  input  logic [7:0]  sw_data,
  output logic        sw_ack,
  output logic        busy,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic [7:0]  cur_pattern
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] PRESC_MAX = CW'(TICK_DIV - 1);

  typedef enum logic {IDLE, WRITE} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic        auto_pend_q, auto_pend_d;
  logic        last_sw_q, last_sw_d;
  logic [7:0]  cur_q, cur_d;
  logic        cs_q, cs_d;
  logic        ack_q, ack_d;
  logic [31:0] wdata_q, wdata_d;

  logic tick, auto_req, grant_sw, grant_auto, do_write;

  function automatic logic [7:0] next_pat(input logic [1:0] m, input logic [7:0] p);
    case (m)
      2'd1:    next_pat = (p == 8'h00) ? 8'h01 : {p[6:0], p[7]};
      2'd2:    next_pat = p + 8'd1;
      2'd3:    next_pat = ~p;
      default: next_pat = p;
    endcase
  endfunction

  always_comb begin
    tick     = enable && (presc_q == PRESC_MAX);
    presc_d  = '0;
    if (enable && !tick) presc_d = presc_q + 1'b1;

    // A pending auto request is dropped, not served, once enable falls.
    auto_req   = auto_pend_q & enable;
    grant_sw   = 1'b0;
    grant_auto = 1'b0;
    if (state_q == IDLE) begin
      if (sw_req && (!auto_req || !last_sw_q)) grant_sw = 1'b1;
      else if (auto_req)                        grant_auto = 1'b1;
    end
    do_write = grant_sw | (grant_auto & (mode != 2'd0));

    state_d   = do_write ? WRITE : IDLE;
    cur_d     = cur_q;
    last_sw_d = last_sw_q;
    if (grant_sw) begin
      cur_d     = sw_data;
      last_sw_d = 1'b1;
    end else if (grant_auto) begin
      last_sw_d = 1'b0;
      if (mode != 2'd0) cur_d = next_pat(mode, cur_q);
    end

    // Grant clears the pending flag; a tick in the same cycle re-arms it.
    auto_pend_d = enable & ((auto_pend_q & ~grant_auto) | (tick & (mode != 2'd0)));

    cs_d    = do_write;
    ack_d   = grant_sw;
    wdata_d = do_write ? {24'b0, cur_d} : 32'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      auto_pend_q <= 1'b0;
      last_sw_q   <= 1'b0;
      cur_q       <= INIT_PATTERN;
      cs_q        <= 1'b0;
      ack_q       <= 1'b0;
      wdata_q     <= 32'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      auto_pend_q <= auto_pend_d;
      last_sw_q   <= last_sw_d;
      cur_q       <= cur_d;
      cs_q        <= cs_d;
      ack_q       <= ack_d;
      wdata_q     <= wdata_d;
    end
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = ~cs_q;
  assign pio_writedata  = wdata_q;
  assign sw_ack         = ack_q;
  assign cur_pattern    = cur_q;
  assign busy           = (state_q == WRITE) | sw_req | auto_pend_q;

endmodule

// File: tb/tb_led_pio_sequencer.sv
// Randomized scoreboard bench for led_pio_sequencer with a cycle-level reference model.
module tb_led_pio_sequencer;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset, enable, sw_req, sw_ack, busy;
  logic [1:0]  mode, pio_address;
  logic [7:0]  sw_data, cur_pattern;
  logic        pio_chipselect, pio_write_n;
  logic [31:0] pio_writedata;

  led_pio_sequencer #(.TICK_DIV(TD), .INIT_PATTERN(8'hFF)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .sw_req(sw_req),
    .sw_data(sw_data), .sw_ack(sw_ack), .busy(busy), .pio_address(pio_address),
    .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata), .cur_pattern(cur_pattern));

  always #5 clk = ~clk;

  typedef struct { int cyc; int data; bit sw; } exp_t;
  exp_t exp_q[$];

  int tests = 0, fails = 0, cyc = 0, nwrites = 0;
  bit running = 1'b1;
  int  exp_cur;
  bit  exp_busy;

  // Reference model state: counter, pending flag, last winner, shadow, write-in-flight.
  int m_cnt, m_cur;
  bit m_pend, m_last_sw, m_inw;

  function automatic int nxt(int m, int p);
    if (m == 1) return (p == 0) ? 1 : (((p * 2) % 256) + (p / 128));
    if (m == 2) return (p + 1) % 256;
    if (m == 3) return 255 - p;
    return p;
  endfunction

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Predicts the outcome of the upcoming clock edge from the current inputs.
  task automatic model_step(output bit got_sw);
    bit tk, areq, gauto;
    got_sw = 1'b0;
    if (reset) begin
      m_cnt = 0; m_pend = 0; m_last_sw = 0; m_cur = 255; m_inw = 0;
      return;
    end
    tk = enable && (m_cnt == TD - 1);
    m_cnt = enable ? (tk ? 0 : m_cnt + 1) : 0;
    gauto = 1'b0;
    if (m_inw) m_inw = 1'b0;
    else begin
      areq = m_pend && enable;
      if (sw_req && (!areq || !m_last_sw)) begin
        got_sw = 1'b1; m_last_sw = 1'b1; m_cur = int'(sw_data);
        m_inw = 1'b1; exp_q.push_back('{cyc + 1, m_cur, 1'b1});
      end else if (areq) begin
        gauto = 1'b1; m_last_sw = 1'b0;
        if (mode != 0) begin
          m_cur = nxt(int'(mode), m_cur);
          m_inw = 1'b1; exp_q.push_back('{cyc + 1, m_cur, 1'b0});
        end
      end
    end
    m_pend = enable && ((m_pend && !gauto) || (tk && mode != 0));
  endtask

  bit sw_hold = 1'b0;

  task automatic cycle(bit r, bit en, int md, bit new_sw, int d);
    bit g;
    #1;
    reset = r; enable = en; mode = 2'(md);
    if (!sw_hold && new_sw) begin sw_hold = 1'b1; sw_data = 8'(d); end
    sw_req = sw_hold;
    exp_cur  = m_cur;
    exp_busy = m_inw | sw_req | m_pend;
    model_step(g);
    if (g) sw_hold = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    @(posedge clk);
    while (running) begin
      @(negedge clk);
      if (!running) break;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check("missed_write", 0, e.data);
      end
      if (pio_chipselect) begin
        nwrites++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          check("writedata", int'(pio_writedata), e.data);
          check("sw_ack", int'(sw_ack), int'(e.sw));
          check("write_n", int'(pio_write_n), 0);
        end else check("spurious_write", int'(pio_writedata), -1);
      end else begin
        check("idle_bus", int'({pio_write_n, sw_ack, pio_writedata}), int'({1'b1, 1'b0, 32'h0}));
      end
      check("address", int'(pio_address), 0);
      check("cur_pattern", int'(cur_pattern), exp_cur);
      check("busy", int'(busy), int'(exp_busy));
    end
  end

  initial begin
    int md;
    bit en;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; sw_req = 1'b0; sw_data = 8'h00;
    m_cur = 255; m_cnt = 0; m_pend = 0; m_last_sw = 0; m_inw = 0;
    exp_cur = 255; exp_busy = 1'b0;
    @(posedge clk);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // Software write of 5A, then bus returns idle.
    cycle(0, 0, 0, 1, 8'h5A);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    // Rotate from FF then from 80, one write per TICK_DIV.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 8'h80);
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, 0, 0);
    // Tie right after reset: software first, then auto.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 2, 0, 0);
    cycle(0, 1, 2, 1, 8'h11);
    for (int i = 0; i < 6; i++) cycle(0, 1, 2, 0, 0);
    // Count wrap FF -> 00, then rotate 00 -> 01.
    cycle(0, 1, 2, 1, 8'hFF);
    for (int i = 0; i < 8; i++) cycle(0, 1, 2, 0, 0);
    cycle(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 0, 0);
    // Mode 0 ticks, and enable dropped with a pending tick.
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 3, 0, 0);
    cycle(0, 1, 3, 1, 8'h3C);
    for (int i = 0; i < 4; i++) cycle(0, 0, 3, 0, 0);
    // Reset during a software WRITE.
    cycle(0, 0, 0, 1, 8'hA5);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    // Randomized traffic.
    md = 1; en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) md = int'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) en = ~en;
      cycle($urandom_range(0, 199) == 0, en, md, $urandom_range(0, 5) == 0,
            int'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    running = 1'b0;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    tests++;
    if (nwrites < 50) begin
      fails++;
      $display("FAIL write_count actual=%0d required>=50", nwrites);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/led_pio_sequencer.md
LED_PIO_SEQUENCER -- requirements
Module: led_pio_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 50000000, sets the prescaler period in clk cycles (minimum 2).
REQ-002 Parameter INIT_PATTERN, default 8'hFF, is the LED pattern in force after reset and matches the PIO reset value.
REQ-003 Port clk  in  1  is the single clock; all logic is on the rising edge.
REQ-004 Port reset  in  1  is the synchronous, active-high reset.
REQ-005 Port enable  in  1  enables the automatic pattern engine.
REQ-006 Port mode  in  2  selects the pattern: 0 hold, 1 rotate-left, 2 count-up, 3 invert (blink).
REQ-007 Port sw_req  in  1  is the software write request, held high until sw_ack.
REQ-008 Port sw_data  in  8  is the software pattern, sampled at grant.
REQ-009 Port sw_ack  out  1  is a one-cycle pulse when the software write is issued.
REQ-010 Port busy  out  1  is high while a write is pending or in progress.
REQ-011 Port pio_address  out  2  is the PIO slave address.
REQ-012 Port pio_chipselect  out  1  is the PIO slave chip-select.
REQ-013 Port pio_write_n  out  1  is the PIO slave write strobe, active-low.
REQ-014 Port pio_writedata  out  32  is the PIO slave write data.
REQ-015 Port cur_pattern  out  8  is a shadow of the last pattern written (or INIT_PATTERN).

Function
REQ-016 The prescaler shall count 0..TICK_DIV-1 while enable=1, pulse tick at count TICK_DIV-1, and wrap to 0.
REQ-017 The prescaler shall be held at 0 with no tick while enable=0.
REQ-018 A tick with mode!=0 shall set auto_pend; a tick while auto_pend is set shall be coalesced with no second write.
REQ-019 enable=0 shall clear auto_pend, and shall not affect the software path.
REQ-020 The FSM shall have exactly two states, IDLE and WRITE, and WRITE shall always return to IDLE after one cycle.
REQ-021 In IDLE with exactly one request pending (sw_req=1 or auto_pend=1), that request shall be granted and the FSM shall enter WRITE.
REQ-022 In IDLE with both requests pending, the grant shall go to the requester not granted last (round-robin); last_grant resets to auto, so software wins the first tie.
REQ-023 At the grant edge, cur_pattern and the PIO outputs shall be registered; a software grant writes sw_data, an auto grant writes next(cur_pattern).
REQ-024 next() for mode 1 shall rotate left by 1 (8'h80 -> 8'h01), with 8'h00 mapping to 8'h01.
REQ-025 next() for mode 2 shall be cur_pattern+1 mod 256 (8'hFF -> 8'h00).
REQ-026 next() for mode 3 shall be the bitwise inverse of cur_pattern.
REQ-027 An auto grant with mode=0 at grant time shall issue no write, shall clear auto_pend, and shall stay in IDLE.
REQ-028 In WRITE, exactly one bus cycle shall be driven: pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata={24'b0,cur_pattern}.
REQ-029 Outside WRITE, the bus shall be idle: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-030 sw_ack shall be 1 only during a WRITE cycle that was granted to software.
REQ-031 auto_pend shall clear at its grant edge; a tick arriving in that same cycle shall re-set it.
REQ-032 sw_req shall be sampled only in IDLE; sw_req still high in the IDLE after ack shall be treated as a new request.
REQ-033 mode changes shall take effect at the next grant and shall not reset the prescaler.
REQ-034 busy = (state==WRITE) | sw_req | auto_pend.
REQ-035 Maximum throughput shall be one PIO write per 2 cycles.

Reset
REQ-036 reset=1 at a clock edge shall force IDLE, prescaler=0, auto_pend=0, last_grant=auto, cur_pattern=INIT_PATTERN, sw_ack=0, and the idle bus of REQ-029, with no write issued after reset.
REQ-037 Reset asserted during WRITE shall abort the write; pio_chipselect shall be 0 in the following cycle.

Verification (TICK_DIV=4)
REQ-038 Software write: sw_req=1, sw_data=8'h5A in IDLE -> next cycle chipselect=1, write_n=0, writedata=32'h5A, sw_ack=1; then the bus returns idle.
REQ-039 Rotate mode: mode=1, enable=1, from 8'hFF then 8'h80 -> writes 8'hFF (rotate of FF), then 8'h01; exactly one write every 4 cycles.
REQ-040 Tie: sw_req and tick in the same cycle after reset -> software granted first, auto write two cycles later; the next tie goes to software only if auto won last.
REQ-041 Count wrap: mode=2, cur_pattern=8'hFF -> writes 8'h00.
REQ-042 Mode 0 and enable toggle: mode=0 ticks -> no bus activity; enable dropped with auto_pend set -> no write, busy=0.
REQ-043 Reset during WRITE -> chipselect=0 next cycle, cur_pattern=8'hFF, sw_ack=0.
